// File: rtl/shift_pkg.sv
// Shared mode codes, FSM state encoding and mode helper for the sequential shifter.
package shift_pkg;

  localparam logic [2:0] MODE_SHL = 3'd0;
  localparam logic [2:0] MODE_SHR = 3'd1;
  localparam logic [2:0] MODE_SAR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Codes above MODE_ROR are reserved and never start an operation.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step used once per clock by the sequencer.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] b,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             cout_next
);

  always_comb begin
    q_next    = b;
    cout_next = 1'b0;
    case (mode)
      MODE_SHL: begin
        q_next    = {b[WIDTH-2:0], sin};
        cout_next = b[WIDTH-1];
      end
      MODE_SHR: begin
        q_next    = {sin, b[WIDTH-1:1]};
        cout_next = b[0];
      end
      MODE_SAR: begin
        q_next    = {b[WIDTH-1], b[WIDTH-1:1]};
        cout_next = b[0];
      end
      MODE_ROL: begin
        q_next    = {b[WIDTH-2:0], b[WIDTH-1]};
        cout_next = b[WIDTH-1];
      end
      MODE_ROR: begin
        q_next    = {b[0], b[WIDTH-1:1]};
        cout_next = b[0];
      end
      default: begin
        q_next    = b;
        cout_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-bit sequential shifter: one bit per clock for a clamped amount, with
// start/busy/done handshake and parallel load. All outputs are registered.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_r, q_d;
  logic             cout_r, cout_d;
  logic             busy_r, busy_d;
  logic             done_r, done_d;
  logic [AW-1:0]    count_q, count_d;
  logic [2:0]       mode_q, mode_d;
  logic [AW-1:0]    amt_clamped;
  logic [WIDTH-1:0] step_q;
  logic             step_cout;

  assign amt_clamped = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode      (mode_q),
    .b         (q_r),
    .sin       (sin),
    .q_next    (step_q),
    .cout_next (step_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_r     <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_q <= '0;
      mode_q  <= MODE_SHL;
    end else begin
      state_q <= state_d;
      q_r     <= q_d;
      cout_r  <= cout_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // A zero-length request finishes straight from IDLE; otherwise the
  // counter holds the steps still to do and the last one raises done.
  always_comb begin
    state_d = state_q;
    q_d     = q_r;
    cout_d  = cout_r;
    busy_d  = busy_r;
    done_d  = 1'b0;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d    = din;
          cout_d = 1'b0;
        end else if (start && is_shift_mode(mode)) begin
          if (amt_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
            count_d = amt_clamped;
            mode_d  = mode;
          end
        end
      end
      SHIFT: begin
        q_d     = step_q;
        cout_d  = step_cout;
        count_d = count_q - AW'(1);
        if (count_q == AW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q    = q_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: stimulus pushes expected results, a
// negedge monitor checks q/cout/busy length/latency on every done pulse.
module tb_shift_seq_unit;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, load, start, sin;
  logic [W-1:0]  din;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          cout, busy, done;

  typedef struct {
    logic [W-1:0] q;
    logic         cout;
    int           k;
    int           start_cyc;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           busy_cnt = 0;
  logic [W-1:0] model_q;
  logic         model_cout;

  shift_seq_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .din    (din),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .sin    (sin),
    .q      (q),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the whole k-step operation as one arithmetic expression,
  // with sin held constant for the duration of the operation.
  function automatic void modelOp(input logic [2:0] m, input int k, input logic s,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] nq, output logic nc);
    int unsigned bi, mask, fill, r;
    bi = b; mask = (1 << W) - 1; r = bi; nc = model_cout;
    if (k == 0) begin
      nq = b;
      return;
    end
    case (m)
      MODE_SHL: begin
        fill = s ? ((1 << k) - 1) : 0;
        r = ((bi << k) | fill) & mask;
        nc = ((bi >> (W - k)) & 1) != 0;
      end
      MODE_SHR, MODE_SAR: begin
        fill = ((m == MODE_SHR) ? s : b[W-1]) ? (mask ^ (mask >> k)) : 0;
        r = (bi >> k) | fill;
        nc = ((bi >> (k - 1)) & 1) != 0;
      end
      MODE_ROL: begin
        r = ((bi << k) | (bi >> (W - k))) & mask;
        nc = (r & 1) != 0;
      end
      default: begin
        r = ((bi >> k) | (bi << (W - k))) & mask;
        nc = ((r >> (W - 1)) & 1) != 0;
      end
    endcase
    nq = r[W-1:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_q"}, 32'(q), 32'(e.q));
        checkOutput({e.tag, "_cout"}, 32'(cout), 32'(e.cout));
        checkOutput({e.tag, "_busy_cycles"}, busy_cnt, e.k);
        checkOutput({e.tag, "_latency"}, cyc - e.start_cyc, e.k + 1);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  task automatic doLoad(input logic [W-1:0] v);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
    checkOutput("load_q", 32'(q), 32'(v));
    checkOutput("load_cout", 32'(cout), 32'(0));
    model_q    = v;
    model_cout = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] m, input int amt, input logic s, input string tag);
    int           k;
    exp_t         e;
    logic [W-1:0] nq;
    logic         nc;
    bit           pulsed;
    pulsed = 1'b0;
    k = (amt > W) ? W : amt;
    mode = m; amount = AW'(amt); sin = s; start = 1'b1;
    if (m <= MODE_ROR) begin
      modelOp(m, k, s, model_q, nq, nc);
      e.q = nq; e.cout = nc; e.k = k; e.start_cyc = cyc; e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (m > MODE_ROR) begin
      repeat (3) @(negedge clk);
      checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
      checkOutput({tag, "_q"}, 32'(q), 32'(model_q));
      return;
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      if (busy && !pulsed) begin
        load = 1'b1; start = 1'b1; din = ~model_q;
        mode = 3'($urandom); amount = AW'($urandom);
        pulsed = 1'b1;
      end else begin
        load = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no done within 40 cycles, expected done", tag);
      sb.delete();
    end
    model_q    = e.q;
    model_cout = e.cout;
  endtask

  initial begin
    logic [2:0] m;
    int         r;
    rst = 1'b1; load = 1'b0; start = 1'b0; sin = 1'b0;
    din = '0; mode = MODE_SHL; amount = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_q", 32'(q), 32'(0));
    checkOutput("reset_cout", 32'(cout), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    rst = 1'b0;
    model_q = '0; model_cout = 1'b0;

    doLoad(8'h80); applyStimulus(MODE_SHL, 1, 1'b0, "shl1_80");
    checkOutput("shl1_80_const", 32'(q), 32'h00);
    doLoad(8'h01); applyStimulus(MODE_SHL, 1, 1'b0, "shl1_01");
    checkOutput("shl1_01_const", 32'(q), 32'h02);
    doLoad(8'h90); applyStimulus(MODE_SAR, 3, 1'b0, "sar3_90");
    checkOutput("sar3_90_const", 32'(q), 32'hF2);
    doLoad(8'h81); applyStimulus(MODE_ROR, 1, 1'b0, "ror1_81");
    checkOutput("ror1_81_const", 32'(q), 32'hC0);
    applyStimulus(MODE_ROL, 8, 1'b0, "rol8_c0");
    checkOutput("rol8_c0_const", 32'(q), 32'hC0);
    applyStimulus(MODE_SHL, 0, 1'b1, "amt0");
    doLoad(8'hFF); applyStimulus(MODE_SHL, 12, 1'b0, "clamp12");
    checkOutput("clamp12_const", 32'(q), 32'h00);
    doLoad(8'h0F); applyStimulus(MODE_SHR, 4, 1'b1, "shr4_sin1");
    checkOutput("shr4_sin1_const", 32'(q), 32'hF0);

    // load and start together: load wins, nothing starts
    load = 1'b1; start = 1'b1; din = 8'h3C; mode = MODE_SHL; amount = AW'(3);
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checkOutput("load_start_q", 32'(q), 32'h3C);
    checkOutput("load_start_busy", 32'(busy), 32'(0));
    repeat (4) @(negedge clk);
    checkOutput("load_start_idle", 32'(busy), 32'(0));
    model_q = 8'h3C; model_cout = 1'b0;

    applyStimulus(3'd6, 3, 1'b0, "reserved6");

    // reset two cycles into an 8-step shift
    mode = MODE_ROL; amount = AW'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_q", 32'(q), 32'(0));
    checkOutput("midreset_cout", 32'(cout), 32'(0));
    checkOutput("midreset_busy", 32'(busy), 32'(0));
    checkOutput("midreset_done", 32'(done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_q = '0; model_cout = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) doLoad(W'($urandom));
      r = $urandom_range(0, 9);
      m = (r < 9) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
      applyStimulus(m, $urandom_range(0, 15), 1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
